axis_fifo_reader: RTL and testbench

AXI-stream master front end for a standard-mode (non-FWFT) native FIFO read port with fixed read latency. Issues `rd_en` speculatively against a credit count, tracks in-flight reads in a latency pipe, lands returned words in a small skid buffer, and presents them as an AXI-stream master. Sits on the read side of any `xpm_fifo_sync`/`xpm_fifo_async` instantiated in `"std"` mode, including BRAM/URAM FIFOs with multi-cycle output registers.

---
 rtl/axis_fifo_reader.sv | 87 ++++++++
 tb/tb_axis_fifo_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_reader.sv
// rtl/axis_fifo_reader.sv - AXI-stream master front end for a standard-mode native FIFO read port
module axis_fifo_reader #(
   parameter int DATA_WIDTH   = 72,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic                  fifo_rd_rst_busy,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_valid,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  err_sync
);

   localparam int BUF_DEPTH = READ_LATENCY + 1;
   localparam int PW        = $clog2(BUF_DEPTH);
   // Must hold count + inflight, which can reach 2*READ_LATENCY + 1.
   localparam int CW        = $clog2(2 * BUF_DEPTH + 1);

   logic [READ_LATENCY-1:0] pipe;
   logic [CW-1:0]           count;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           credit_use;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [DATA_WIDTH-1:0]   skid_mem [BUF_DEPTH];
   logic                    land;
   logic                    pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign land          = pipe[READ_LATENCY-1];
   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = skid_mem[rd_ptr];
   assign pop           = m_axis_tvalid & m_axis_tready;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + CW'(pipe[i]);
      end
   end

   // A pop in this cycle frees its slot in time for a read issued now.
   assign credit_use = count + inflight - CW'(pop);
   assign fifo_rd_en = rst_n & ~fifo_empty & ~fifo_rd_rst_busy & (credit_use < CW'(BUF_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe     <= '0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         err_sync <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            skid_mem[i] <= '0;
         end
      end else begin
         pipe <= READ_LATENCY'({pipe, fifo_rd_en});

         if (land) begin
            skid_mem[wr_ptr] <= fifo_dout;
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end

         if (land && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !land) begin
            count <= count - 1'b1;
         end

         if ((land != fifo_valid) || (land && !pop && (count == CW'(BUF_DEPTH)))) begin
            err_sync <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis_fifo_reader.sv
// tb/tb_axis_fifo_reader.sv - self-checking bench for axis_fifo_reader at READ_LATENCY 1..4
module tb_axis_fifo_reader;

   localparam int DW = 72;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int written [1:4];
   int rd_cnt  [1:4];
   int exp_idx [1:4];
   int base    [1:4];
   int snap    [1:4];

   logic force_empty [1:4];
   logic busy        [1:4];
   logic tready      [1:4];
   logic inject      [1:4];
   logic allow_err   [1:4];
   logic empty       [1:4];
   logic rd_en       [1:4];
   logic fvalid      [1:4];
   logic tvalid      [1:4];
   logic err         [1:4];
   logic [DW-1:0] dout  [1:4];
   logic [DW-1:0] tdata [1:4];

   int first_rd, first_v, last_v, beats, cyc;
   logic all_done;

   typedef struct {
      int   l;
      logic empty_in;
      logic busy_in;
      logic ready_in;
      logic exp_rd_en;
      logic exp_tvalid;
   } vec_t;

   vec_t idle_vecs [4];
   vec_t full_vecs [4];

   // The k-th word ever written into FIFO number l.
   function automatic logic [DW-1:0] word_val(input int l, input int k);
      logic [31:0] h;
      h = k * 32'h9E37_79B9;
      return {8'(l), h, 32'(k)};
   endfunction

   task automatic chk(input string name, input int l, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s L=%0d: got %h, expected %h", name, l, act, exp);
   endtask

   for (genvar L = 1; L <= 4; L++) begin : g
      logic [L-1:0]  sv;
      int            si [L];
      logic          stall_q;
      logic [DW-1:0] stall_data;

      assign empty[L]  = force_empty[L] | (written[L] == rd_cnt[L]);
      assign fvalid[L] = sv[L-1] | inject[L];
      assign dout[L]   = word_val(L, si[L-1]);

      axis_fifo_reader #(.DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .fifo_empty       (empty[L]),
         .fifo_rd_rst_busy (busy[L]),
         .fifo_rd_en       (rd_en[L]),
         .fifo_dout        (dout[L]),
         .fifo_valid       (fvalid[L]),
         .m_axis_tvalid    (tvalid[L]),
         .m_axis_tready    (tready[L]),
         .m_axis_tdata     (tdata[L]),
         .err_sync         (err[L])
      );

      // Native FIFO model: the n-th read returns word n after L cycles.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sv <= '0;
         end else begin
            sv <= L'({sv, rd_en[L]});
            for (int i = L - 1; i > 0; i--) si[i] <= si[i-1];
            si[0] <= rd_cnt[L];
            if (rd_en[L]) rd_cnt[L] <= rd_cnt[L] + 1;
         end
      end

      // Scoreboard and protocol monitor.
      always @(negedge clk) begin
         if (!rst_n) begin
            exp_idx[L] = rd_cnt[L];
            stall_q    = 1'b0;
         end else begin
            chk("credit_bound", L, DW'((rd_cnt[L] - exp_idx[L]) <= (L + 1)), DW'(1));
            chk("rd_en_gated", L, DW'(rd_en[L] & (empty[L] | busy[L])), DW'(0));
            if (!allow_err[L]) chk("err_sync_low", L, DW'(err[L]), DW'(0));
            if (stall_q) begin
               chk("tvalid_held", L, DW'(tvalid[L]), DW'(1));
               chk("tdata_stable", L, tdata[L], stall_data);
            end
            if (tvalid[L] && tready[L]) begin
               chk("data_order", L, tdata[L], word_val(L, exp_idx[L]));
               exp_idx[L]++;
            end
            stall_q    = tvalid[L] & ~tready[L];
            stall_data = tdata[L];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int l, input int target, input int budget);
      int c;
      c = 0;
      while (exp_idx[l] < target && c < budget) begin
         step();
         c++;
      end
      chk("drained", l, DW'(exp_idx[l]), DW'(target));
   endtask

   task automatic apply_vecs(input vec_t v);
      int   sw;
      logic sb, sr, se;
      @(negedge clk);
      #1;
      sw = written[v.l]; sb = busy[v.l]; sr = tready[v.l]; se = force_empty[v.l];
      if (v.empty_in) force_empty[v.l] = 1'b1;
      else if (written[v.l] == rd_cnt[v.l]) written[v.l] = rd_cnt[v.l] + 1;
      busy[v.l]   = v.busy_in;
      tready[v.l] = v.ready_in;
      #1;
      chk("vec_rd_en", v.l, DW'(rd_en[v.l]), DW'(v.exp_rd_en));
      chk("vec_tvalid", v.l, DW'(tvalid[v.l]), DW'(v.exp_tvalid));
      written[v.l] = sw; busy[v.l] = sb; tready[v.l] = sr; force_empty[v.l] = se;
   endtask

   initial begin
      idle_vecs[0] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      idle_vecs[1] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      idle_vecs[2] = '{2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      idle_vecs[3] = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      full_vecs[0] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      full_vecs[1] = '{3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      full_vecs[2] = '{3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      full_vecs[3] = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0;
      for (int l = 1; l <= 4; l++) begin
         force_empty[l] = 1'b0; busy[l] = 1'b0; tready[l] = 1'b0;
         inject[l] = 1'b0; allow_err[l] = 1'b0;
      end
      repeat (2) step();
      for (int l = 1; l <= 4; l++) begin
         chk("rst_tvalid", l, DW'(tvalid[l]), DW'(0));
         chk("rst_rd_en", l, DW'(rd_en[l]), DW'(0));
         chk("rst_err", l, DW'(err[l]), DW'(0));
         chk("rst_tdata", l, tdata[l], DW'(0));
      end
      rst_n = 1'b1;
      repeat (5) step();
      for (int l = 1; l <= 4; l++) chk("idle_no_reads", l, DW'(rd_cnt[l]), DW'(0));

      for (int i = 0; i < 4; i++) apply_vecs(idle_vecs[i]);

      // Streaming, READ_LATENCY 2.
      step();
      tready[2] = 1'b1;
      written[2] += 64;
      first_rd = -1; first_v = -1; last_v = -1; beats = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rd_en[2] && first_rd < 0) first_rd = c;
         if (tvalid[2]) begin
            if (first_v < 0) first_v = c;
            last_v = c;
            beats++;
         end
      end
      chk("stream_first_latency", 2, DW'(first_v - first_rd), DW'(3));
      chk("stream_beats", 2, DW'(beats), DW'(64));
      chk("stream_no_bubbles", 2, DW'(last_v - first_v), DW'(63));
      chk("stream_delivered", 2, DW'(exp_idx[2]), DW'(64));

      // Back-pressure, READ_LATENCY 3.
      step();
      tready[3] = 1'b0;
      written[3] += 20;
      repeat (15) step();
      chk("bp_rd_pulses", 3, DW'(rd_cnt[3]), DW'(4));
      chk("bp_rd_en_low", 3, DW'(rd_en[3]), DW'(0));
      chk("bp_tvalid", 3, DW'(tvalid[3]), DW'(1));
      chk("bp_tdata_word0", 3, tdata[3], word_val(3, 0));
      for (int i = 0; i < 4; i++) apply_vecs(full_vecs[i]);
      step();
      tready[3] = 1'b1;
      #1;
      chk("bp_release_rd_en", 3, DW'(rd_en[3]), DW'(1));
      wait_drain(3, 20, 100);
      chk("bp_all_read", 3, DW'(rd_cnt[3]), DW'(20));

      // Read-reset busy, READ_LATENCY 1.
      step();
      tready[1] = 1'b1;
      busy[1] = 1'b1;
      written[1] += 10;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("busy_no_rd_en", 1, DW'(rd_en[1]), DW'(0));
      end
      @(posedge clk);
      #1;
      busy[1] = 1'b0;
      #1;
      chk("busy_resume", 1, DW'(rd_en[1]), DW'(1));
      wait_drain(1, 10, 100);

      // Error flag, READ_LATENCY 4.
      step();
      allow_err[4] = 1'b1;
      inject[4] = 1'b1;
      @(negedge clk);
      chk("err_before_edge", 4, DW'(err[4]), DW'(0));
      step();
      inject[4] = 1'b0;
      @(negedge clk);
      chk("err_set", 4, DW'(err[4]), DW'(1));
      repeat (5) step();
      chk("err_sticky", 4, DW'(err[4]), DW'(1));

      // Reset mid-stream on READ_LATENCY 2.
      step();
      written[2] += 30;
      tready[2] = 1'b1;
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      for (int l = 1; l <= 4; l++) begin
         chk("mid_rst_tvalid", l, DW'(tvalid[l]), DW'(0));
         chk("mid_rst_rd_en", l, DW'(rd_en[l]), DW'(0));
         chk("mid_rst_err", l, DW'(err[l]), DW'(0));
         chk("mid_rst_tdata", l, tdata[l], DW'(0));
         written[l] = rd_cnt[l];
      end
      allow_err[4] = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      for (int l = 1; l <= 4; l++) snap[l] = rd_cnt[l];
      repeat (5) step();
      for (int l = 1; l <= 4; l++) begin
         chk("post_rst_no_reads", l, DW'(rd_cnt[l]), DW'(snap[l]));
         chk("post_rst_tvalid", l, DW'(tvalid[l]), DW'(0));
      end

      // Random stall with toggling empty on all four latencies.
      for (int l = 1; l <= 4; l++) base[l] = exp_idx[l];
      cyc = 0;
      all_done = 1'b0;
      while (!all_done && cyc < 40000) begin
         step();
         all_done = 1'b1;
         for (int l = 1; l <= 4; l++) begin
            tready[l] = 1'($urandom_range(0, 1));
            force_empty[l] = ($urandom_range(0, 4) == 0);
            if ((written[l] - rd_cnt[l]) < 6 && $urandom_range(0, 2) != 0)
               written[l] += int'($urandom_range(1, 3));
            if (exp_idx[l] - base[l] < 2500) all_done = 1'b0;
         end
         cyc++;
      end
      for (int l = 1; l <= 4; l++) begin
         chk("random_words", l, DW'(exp_idx[l] - base[l] >= 2500), DW'(1));
         force_empty[l] = 1'b0;
         tready[l] = 1'b1;
      end
      for (int l = 1; l <= 4; l++) wait_drain(l, written[l], 200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
